// File: rtl/cache_ro_sa.sv
// 2-way set-associative read-only instruction cache with 4-word blocks,
// per-set LRU replacement, whole-cache flush and saturating hit/miss counters.
module cache_ro_sa #(
  parameter int unsigned SET_BITS = 2,
  parameter int unsigned TAG_W    = 28 - SET_BITS,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             proc_reset_n,
  input  logic [29:0]      proc_addr,
  input  logic             proc_flush,
  output logic [31:0]      proc_rdata,
  output logic             proc_stall,
  output logic             mem_read,
  output logic [27:0]      mem_addr,
  input  logic [127:0]     mem_rdata,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned Sets = 1 << SET_BITS;

  typedef enum logic [0:0] {StStart, StAllocate} state_e;

  state_e state_q, state_d;

  logic [1:0][Sets-1:0] valid_q, valid_d;
  logic [Sets-1:0]      lru_q, lru_d;
  logic [CNT_W-1:0]     hit_cnt_q, miss_cnt_q;

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  logic [TAG_W-1:0] tag_q  [2][Sets];
  logic [127:0]     data_q [2][Sets];

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_W-1:0]    tag;
  logic [1:0]          word;
  logic                hit0, hit1;
  logic                victim;
  logic                fill;
  logic                hit_inc, miss_inc;
  logic [127:0]        hit_block;

  assign set_idx  = proc_addr[SET_BITS+1:2];
  assign tag      = proc_addr[29:SET_BITS+2];
  assign word     = proc_addr[1:0];
  assign mem_addr = proc_addr[29:2];
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  assign hit0      = valid_q[0][set_idx] && (tag_q[0][set_idx] == tag);
  assign hit1      = valid_q[1][set_idx] && (tag_q[1][set_idx] == tag);
  assign hit_block = hit1 ? data_q[1][set_idx] : data_q[0][set_idx];

  // Fill invalid ways first (way 0 before way 1), otherwise the LRU way.
  assign victim = !valid_q[0][set_idx] ? 1'b0 :
                  !valid_q[1][set_idx] ? 1'b1 : lru_q[set_idx];

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    lru_d      = lru_q;
    proc_stall = 1'b1;
    proc_rdata = 32'h0;
    mem_read   = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    fill       = 1'b0;
    unique case (state_q)
      StStart: begin
        if (proc_flush) begin
          valid_d = '0;
          lru_d   = '0;
        end else if (hit0 || hit1) begin
          proc_stall     = 1'b0;
          proc_rdata     = hit_block[{word, 5'b0} +: 32];
          lru_d[set_idx] = hit0;
          hit_inc        = 1'b1;
        end else begin
          miss_inc = 1'b1;
          state_d  = StAllocate;
        end
      end
      StAllocate: begin
        mem_read = 1'b1;
        if (proc_flush) begin
          // A flush beats a coincident fill: the block is dropped.
          valid_d = '0;
          lru_d   = '0;
          if (mem_ready) state_d = StStart;
        end else if (mem_ready) begin
          fill                    = 1'b1;
          valid_d[victim][set_idx] = 1'b1;
          lru_d[set_idx]          = ~victim;
          state_d                 = StStart;
        end
      end
      default: state_d = StStart;
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q    <= StStart;
      valid_q    <= '0;
      lru_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      lru_q   <= lru_d;
      if (hit_inc && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[victim][set_idx]  <= tag;
      data_q[victim][set_idx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_cache_ro_sa.sv
// Directed bench for cache_ro_sa: a 32-bit-counter instance and a 4-bit-counter
// instance share all inputs so saturation can be observed alongside normal counting.
module tb_cache_ro_sa;

  logic         clk = 1'b0;
  logic         proc_reset_n;
  logic [29:0]  proc_addr;
  logic         proc_flush;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [31:0]  hit_cnt, miss_cnt;

  logic [31:0]  c4_rdata;
  logic         c4_stall, c4_mem_read;
  logic [27:0]  c4_mem_addr;
  logic [3:0]   c4_hit_cnt, c4_miss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_ro_sa dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .proc_addr    (proc_addr),
    .proc_flush   (proc_flush),
    .proc_rdata   (proc_rdata),
    .proc_stall   (proc_stall),
    .mem_read     (mem_read),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  cache_ro_sa #(.CNT_W(4)) dut_c4 (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .proc_addr    (proc_addr),
    .proc_flush   (proc_flush),
    .proc_rdata   (c4_rdata),
    .proc_stall   (c4_stall),
    .mem_read     (c4_mem_read),
    .mem_addr     (c4_mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .hit_cnt      (c4_hit_cnt),
    .miss_cnt     (c4_miss_cnt)
  );

  // Memory image: word k of block b = {b-1, k+1, k+1} (block 1 = 0x44,0x33,0x22,0x11).
  function automatic logic [127:0] blk(input logic [27:0] b);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = {b[23:0] - 24'd1, 4'(k + 1), 4'(k + 1)};
    return r;
  endfunction

  task automatic do_reset();
    proc_reset_n = 1'b0;
    proc_flush   = 1'b0;
    mem_ready    = 1'b0;
    mem_rdata    = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    proc_reset_n = 1'b1;
  endtask

  // Presents addr until stall drops; memory answers on ALLOCATE cycle delay+1.
  // Starts and ends 1 time unit after a rising edge. stalls=999 flags a timeout.
  task automatic access(input logic [29:0] a, input int delay, output int stalls,
                        output int reads, output logic [27:0] maddr,
                        output logic [31:0] data);
    int alloc = 0;
    stalls = 0;
    reads  = 0;
    maddr  = '0;
    data   = '0;
    proc_addr = a;
    for (int i = 0; i < 40; i++) begin
      if (mem_read) begin
        alloc++;
        reads++;
        maddr = mem_addr;
      end
      mem_ready = mem_read && (alloc == delay + 1);
      mem_rdata = blk(mem_addr);
      @(negedge clk);
      if (!proc_stall) begin
        data = proc_rdata;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        return;
      end
      stalls++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    stalls    = 999;
  endtask

  task automatic test_reset();
    proc_reset_n = 1'b0;
    proc_addr    = 30'h4;
    proc_flush   = 1'b0;
    mem_ready    = 1'b1;
    mem_rdata    = blk(28'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (proc_stall !== 1'b1) begin errors++; $display("FAIL reset_stall got %b want 1", proc_stall); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b want 0", mem_read); end
    checks++; if (proc_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", proc_rdata); end
    checks++; if (hit_cnt !== 32'h0) begin errors++; $display("FAIL reset_hit_cnt got %0d want 0", hit_cnt); end
    checks++; if (miss_cnt !== 32'h0) begin errors++; $display("FAIL reset_miss_cnt got %0d want 0", miss_cnt); end
    checks++; if (mem_addr !== 28'h1) begin errors++; $display("FAIL reset_mem_addr got %h want 1", mem_addr); end
    mem_ready = 1'b0;
  endtask

  task automatic test_miss_fill();
    int st, rd;
    logic [27:0] ma;
    logic [31:0] d;
    do_reset();
    access(30'h4, 2, st, rd, ma, d);
    checks++; if (st !== 4) begin errors++; $display("FAIL miss_stall_cycles got %0d want 4", st); end
    checks++; if (rd !== 3) begin errors++; $display("FAIL miss_read_cycles got %0d want 3", rd); end
    checks++; if (ma !== 28'h1) begin errors++; $display("FAIL miss_mem_addr got %h want 1", ma); end
    checks++; if (d !== 32'h11) begin errors++; $display("FAIL miss_rdata got %h want 00000011", d); end
    checks++; if (miss_cnt !== 32'd1) begin errors++; $display("FAIL miss_miss_cnt got %0d want 1", miss_cnt); end
    checks++; if (hit_cnt !== 32'd1) begin errors++; $display("FAIL miss_hit_cnt got %0d want 1", hit_cnt); end
  endtask

  task automatic test_lru();
    int st, rd;
    logic [27:0] ma;
    logic [31:0] d;
    do_reset();
    access(30'h00, 0, st, rd, ma, d);
    checks++; if (st !== 2) begin errors++; $display("FAIL lru_a_fill got %0d want 2", st); end
    access(30'h10, 1, st, rd, ma, d);
    checks++; if (st !== 3) begin errors++; $display("FAIL lru_b_fill got %0d want 3", st); end
    access(30'h00, 0, st, rd, ma, d);
    checks++; if (st !== 0) begin errors++; $display("FAIL lru_a_hit got %0d want 0", st); end
    access(30'h20, 0, st, rd, ma, d);
    checks++; if (d !== 32'h711) begin errors++; $display("FAIL lru_c_data got %h want 00000711", d); end
    access(30'h00, 0, st, rd, ma, d);
    checks++; if (st !== 0) begin errors++; $display("FAIL lru_a_kept got %0d want 0", st); end
    access(30'h10, 0, st, rd, ma, d);
    checks++; if (st !== 2) begin errors++; $display("FAIL lru_b_evicted got %0d want 2", st); end
    checks++; if (miss_cnt !== 32'd4) begin errors++; $display("FAIL lru_miss_cnt got %0d want 4", miss_cnt); end
    checks++; if (hit_cnt !== 32'd6) begin errors++; $display("FAIL lru_hit_cnt got %0d want 6", hit_cnt); end
  endtask

  // Relies on block 4 (addr 0x10) resident from test_lru.
  task automatic test_words();
    int st, rd;
    logic [27:0] ma;
    logic [31:0] d;
    logic [31:0] exp_w [4] = '{32'h311, 32'h322, 32'h333, 32'h344};
    for (int k = 0; k < 4; k++) begin
      access(30'h10 + 30'(k), 0, st, rd, ma, d);
      checks++; if (st !== 0 || d !== exp_w[k]) begin
        errors++; $display("FAIL word%0d got stalls=%0d data=%h want 0 %h", k, st, d, exp_w[k]);
      end
    end
    checks++; if (hit_cnt !== 32'd10) begin errors++; $display("FAIL words_hit_cnt got %0d want 10", hit_cnt); end
  endtask

  task automatic test_flush();
    int st, rd;
    logic [27:0] ma;
    logic [31:0] d;
    do_reset();
    access(30'h00, 0, st, rd, ma, d);
    proc_flush = 1'b1;
    @(negedge clk);
    checks++; if (proc_stall !== 1'b1) begin errors++; $display("FAIL flush_stall got %b want 1", proc_stall); end
    @(posedge clk); #1;
    proc_flush = 1'b0;
    checks++; if (hit_cnt !== 32'd1) begin errors++; $display("FAIL flush_no_count got %0d want 1", hit_cnt); end
    access(30'h00, 0, st, rd, ma, d);
    checks++; if (st !== 2 || rd !== 1) begin
      errors++; $display("FAIL flush_remiss got stalls=%0d reads=%0d want 2 1", st, rd);
    end
    checks++; if (miss_cnt !== 32'd2) begin errors++; $display("FAIL flush_miss_cnt got %0d want 2", miss_cnt); end
  endtask

  task automatic test_flush_ready();
    int st, rd;
    logic [27:0] ma;
    logic [31:0] d;
    do_reset();
    proc_addr = 30'h40;
    @(posedge clk); #1;
    mem_ready  = 1'b1;
    proc_flush = 1'b1;
    mem_rdata  = blk(28'h10);
    @(negedge clk);
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL fr_mem_read got %b want 1", mem_read); end
    @(posedge clk); #1;
    mem_ready  = 1'b0;
    proc_flush = 1'b0;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL fr_state_start got %b want 0", mem_read); end
    access(30'h40, 0, st, rd, ma, d);
    checks++; if (st !== 2 || rd !== 1) begin
      errors++; $display("FAIL fr_remiss got stalls=%0d reads=%0d want 2 1", st, rd);
    end
    checks++; if (d !== 32'hF11) begin errors++; $display("FAIL fr_data got %h want 00000f11", d); end
    checks++; if (miss_cnt !== 32'd2) begin errors++; $display("FAIL fr_miss_cnt got %0d want 2", miss_cnt); end
  endtask

  task automatic test_back_to_back();
    int st, rd;
    logic [27:0] ma;
    logic [31:0] d;
    do_reset();
    access(30'h00, 0, st, rd, ma, d);
    access(30'h10, 0, st, rd, ma, d);
    access(30'h10, 0, st, rd, ma, d);
    checks++; if (st !== 0) begin errors++; $display("FAIL b2b_hit_b got %0d want 0", st); end
    access(30'h00, 0, st, rd, ma, d);
    checks++; if (st !== 0) begin errors++; $display("FAIL b2b_hit_a got %0d want 0", st); end
    access(30'h20, 0, st, rd, ma, d);
    access(30'h00, 0, st, rd, ma, d);
    checks++; if (st !== 0) begin errors++; $display("FAIL b2b_a_kept got %0d want 0", st); end
    access(30'h10, 0, st, rd, ma, d);
    checks++; if (st !== 2) begin errors++; $display("FAIL b2b_b_evicted got %0d want 2", st); end
  endtask

  task automatic test_saturate_and_reset();
    int st, rd;
    logic [27:0] ma;
    logic [31:0] d;
    do_reset();
    access(30'h4, 0, st, rd, ma, d);
    repeat (20) begin
      @(posedge clk); #1;
    end
    checks++; if (c4_hit_cnt !== 4'hF) begin errors++; $display("FAIL sat_c4_hit got %h want f", c4_hit_cnt); end
    checks++; if (hit_cnt !== 32'd21) begin errors++; $display("FAIL sat_hit32 got %0d want 21", hit_cnt); end
    checks++; if (c4_miss_cnt !== 4'd1) begin errors++; $display("FAIL sat_c4_miss got %0d want 1", c4_miss_cnt); end
    proc_addr = 30'h8;
    @(posedge clk); #1;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rst_pre_mem_read got %b want 1", mem_read); end
    proc_reset_n = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_async_mem_read got %b want 0", mem_read); end
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_counters got %0d %0d want 0 0", hit_cnt, miss_cnt);
    end
    @(posedge clk); #1;
    proc_reset_n = 1'b1;
    mem_ready    = 1'b1;
    mem_rdata    = {4{32'hDEADBEEF}};
    @(posedge clk); #1;
    mem_ready = 1'b0;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rst_ready_ignored got %b want 1", mem_read); end
    access(30'h8, 0, st, rd, ma, d);
    checks++; if (st !== 1 || d !== 32'h111) begin
      errors++; $display("FAIL rst_refill got stalls=%0d data=%h want 1 00000111", st, d);
    end
    checks++; if (miss_cnt !== 32'd1) begin errors++; $display("FAIL rst_miss_cnt got %0d want 1", miss_cnt); end
  endtask

  initial begin
    proc_reset_n = 1'b0;
    proc_addr    = '0;
    proc_flush   = 1'b0;
    mem_ready    = 1'b0;
    mem_rdata    = '0;
    test_reset();
    test_miss_fill();
    test_lru();
    test_words();
    test_flush();
    test_flush_ready();
    test_back_to_back();
    test_saturate_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
